regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
Shares the register file's single write port between two writeback requesters: requester 0 (ALU result) and requester 1 (memory load result). Each requester has a one-entry holding slot with a valid/ready handshake. Slots drain to the write port under round-robin arbitration, with oldest-first ordering when both slots target the same register. The block also exports a pending-write scoreboard and read-hazard flags for the decode stage. It sits between the writeback stage and the Register_File write port (Register_Write / Write_Reg / Register_Write_Data).

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width (2**ADDR_W registers)
ZERO_DISCARD, 1, when 1, requests to register 0 are accepted and dropped (never written)

Ports:
Clk  in  1  clock; all state updates on rising edge
Reset  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 offers a write
req0_ready  out  1  requester 0 slot can accept
req0_addr  in  ADDR_W  requester 0 destination register
req0_data  in  DATA_W  requester 0 write data
req1_valid / req1_ready / req1_addr / req1_data  same as requester 0, for requester 1
Register_Write  out  1  write enable to register file
Write_Reg  out  ADDR_W  write address to register file
Register_Write_Data  out  DATA_W  write data to register file
Read_Reg_1, Read_Reg_2  in  ADDR_W  decode-stage read addresses
hazard_1, hazard_2  out  1  read address has a write pending in a slot
pending  out  2**ADDR_W  bit i set while any full slot targets register i

Behaviour:
- Reset (asynchronous, immediate): both slots empty, age bit cleared, rr pointer = requester 0. All outputs 0 except readies = 1. Any in-flight writes are lost.
- Accept: handshake on rising Clk when reqN_valid & reqN_ready; the slot loads addr/data.
- reqN_ready = slot N empty, or slot N granted this cycle (same-edge drain-and-refill allowed).
- ZERO_DISCARD=1 and addr==0:
  - handshake completes but the slot does not load;
  - no write is issued and pending is unaffected.
- Issue (combinational from slot state):
  - Register_Write = 1 whenever any slot is full; Write_Reg / Register_Write_Data driven from the granted slot.
  - The register file captures on the same edge. Latency: accepted at edge N, written at edge N+1.
- Grant rules:
  - Only one slot full: grant it.
  - Both full, different addresses: grant the requester at the rr pointer; pointer then toggles to the other requester.
  - Both full, same address: grant the older slot (age bit), so the later write wins in the register file; rr pointer unchanged.
- Age bit: records which slot was loaded first. If both slots load on the same edge while both are empty, requester 0 is treated as older.
- Grant clears the slot at the edge unless it is refilled on that edge.
- Both slots idle: Register_Write = 0; Write_Reg and Register_Write_Data hold 0.
- pending: OR of one-hot decodes of full slots. Register 0 is never set when ZERO_DISCARD=1.
- Hazard flags: hazard_k = pending[Read_Reg_k], purely combinational.
- Throughput: one write per cycle sustained. With both requesters streaming, each gets every other cycle.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults, the requester index constants (REQ_ALU=0, REQ_MEM=1), and a write-slot record type (valid, addr, data).
- One natural sub-module: wb_slot (one-entry holding register with load/clear/ready logic), instantiated twice.
- Arbitration, age bit, and scoreboard decode stay in the top module.

Test Plan:
- Single write: req0 valid addr=2 data=40 at edge 0 -> Register_Write=1, Write_Reg=2, data=40 during cycle 1; pending[2]=1 then 0; reg 2 reads 40.
- Simultaneous requests: req0 (4,80) and req1 (8,160) on the same edge -> writes in consecutive cycles, req0 first (rr at reset), then req1; both slots accept again after draining.
- Same-address ordering: req1 (16,320) accepted, next edge req0 (16,999) -> reg 16 written 320 then 999; final read = 999.
- Zero discard: req0 addr=0 data=20 -> ready=1, no Register_Write, pending[0]=0; register 0 unchanged.
- Hazard flag: slot holds addr 31, Read_Reg_1=31, Read_Reg_2=8 -> hazard_1=1, hazard_2=0; both 0 after the write issues.
- Async reset mid-operation: both slots full, assert Reset between edges -> immediately Register_Write=0, pending=0, readies=1; no write of the held data after release.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: default widths,
// requester index constants and the write-slot record type.
package regfile_write_arbiter_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;

  // Requester indices; also the encoding of the grant select and rr pointer.
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;

  // One pending register write at the default widths.
  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wr_slot_t;

endpackage

// File: rtl/regfile_write_arbiter_wb_slot.sv
// wb_slot: one-entry writeback holding register with valid/ready handshake.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   valid               requester offers a write
//   discard             accept the handshake without loading (register-0 drop)
//   grant               arbiter drains this slot at the coming edge
//   wr_addr, wr_data    incoming destination register and data
//   ready               slot can accept (empty, or draining this cycle)
//   load                slot captures wr_addr/wr_data at the coming edge
//   full                slot holds a pending write
//   slot_addr/slot_data held destination register and data
module wb_slot #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              discard,
  input  logic              grant,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              ready,
  output logic              load,
  output logic              full,
  output logic [ADDR_W-1:0] slot_addr,
  output logic [DATA_W-1:0] slot_data
);

  // A granted slot empties at the edge, so it may be refilled on that edge.
  assign ready = !full || grant;
  assign load  = valid && ready && !discard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full      <= 1'b0;
      slot_addr <= '0;
      slot_data <= '0;
    end else if (load) begin
      full      <= 1'b1;
      slot_addr <= wr_addr;
      slot_data <= wr_data;
    end else if (grant) begin
      full      <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register file's single write port between
// requester 0 (ALU result) and requester 1 (memory load result). Each has a
// one-entry slot; full slots drain round-robin, oldest-first when both slots
// target the same register. Exports a pending-write scoreboard and hazard flags.
// Ports:
//   Clk, Reset                       clock, asynchronous active-high reset
//   reqN_valid/ready/addr/data       writeback handshake for requester N
//   Register_Write/Write_Reg/
//   Register_Write_Data              register file write port
//   Read_Reg_1/2, hazard_1/2         decode read addresses and pending flags
//   pending                          one bit per register with a write pending
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter bit          ZERO_DISCARD = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_W-1:0]     req0_addr,
  input  logic [DATA_W-1:0]     req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_W-1:0]     req1_addr,
  input  logic [DATA_W-1:0]     req1_data,
  output logic                  Register_Write,
  output logic [ADDR_W-1:0]     Write_Reg,
  output logic [DATA_W-1:0]     Register_Write_Data,
  input  logic [ADDR_W-1:0]     Read_Reg_1,
  input  logic [ADDR_W-1:0]     Read_Reg_2,
  output logic                  hazard_1,
  output logic                  hazard_2,
  output logic [(1<<ADDR_W)-1:0] pending
);

  logic              full0, full1, load0, load1, gnt0, gnt1;
  logic              discard0, discard1;
  logic              gnt_sel, rr_ptr, older1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] data0, data1;

  assign discard0 = ZERO_DISCARD && (req0_addr == '0);
  assign discard1 = ZERO_DISCARD && (req1_addr == '0);

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot0 (
    .clk(Clk), .rst(Reset), .valid(req0_valid), .discard(discard0), .grant(gnt0),
    .wr_addr(req0_addr), .wr_data(req0_data), .ready(req0_ready), .load(load0),
    .full(full0), .slot_addr(addr0), .slot_data(data0)
  );

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot1 (
    .clk(Clk), .rst(Reset), .valid(req1_valid), .discard(discard1), .grant(gnt1),
    .wr_addr(req1_addr), .wr_data(req1_data), .ready(req1_ready), .load(load1),
    .full(full1), .slot_addr(addr1), .slot_data(data1)
  );

  // Same-address pairs go oldest first so the later write lands last.
  always_comb begin
    gnt_sel = REQ_ALU;
    if (full0 && full1) begin
      if (addr0 == addr1) gnt_sel = older1 ? REQ_MEM : REQ_ALU;
      else                gnt_sel = rr_ptr;
    end else if (full1) begin
      gnt_sel = REQ_MEM;
    end
    gnt0 = full0 && (gnt_sel == REQ_ALU);
    gnt1 = full1 && (gnt_sel == REQ_MEM);
  end

  // older1 = 1 means slot 1 was loaded before slot 0. A slot loading alone
  // becomes the younger one; both loading together leaves slot 0 older.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rr_ptr <= REQ_ALU;
      older1 <= 1'b0;
    end else begin
      if (full0 && full1 && (addr0 != addr1)) rr_ptr <= ~gnt_sel;
      if (load1)      older1 <= 1'b0;
      else if (load0) older1 <= 1'b1;
    end
  end

  always_comb begin
    Register_Write      = full0 || full1;
    Write_Reg           = '0;
    Register_Write_Data = '0;
    if (gnt0) begin
      Write_Reg           = addr0;
      Register_Write_Data = data0;
    end else if (gnt1) begin
      Write_Reg           = addr1;
      Register_Write_Data = data1;
    end
  end

  always_comb begin
    pending = '0;
    if (full0) pending[addr0] = 1'b1;
    if (full1) pending[addr1] = 1'b1;
  end

  assign hazard_1 = pending[Read_Reg_1];
  assign hazard_2 = pending[Read_Reg_2];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: expected writes are queued
// when stimulus is driven and compared in order as the write port fires.
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  logic        Clk, Reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]  req0_addr, req1_addr, Write_Reg, Read_Reg_1, Read_Reg_2;
  logic [31:0] req0_data, req1_data, Register_Write_Data, pending;
  logic        Register_Write, hazard_1, hazard_2;

  int n_compared   = 0;
  int n_mismatched = 0;

  wr_slot_t    sb[$];
  logic [31:0] rf [32];

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .ZERO_DISCARD(1'b1)) dut (
    .Clk(Clk), .Reset(Reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .Register_Write(Register_Write), .Write_Reg(Write_Reg), .Register_Write_Data(Register_Write_Data),
    .Read_Reg_1(Read_Reg_1), .Read_Reg_2(Read_Reg_2), .hazard_1(hazard_1), .hazard_2(hazard_2),
    .pending(pending)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_write(input logic [4:0] a, input logic [31:0] d);
    wr_slot_t e;
    e.valid = 1'b1;
    e.addr  = a;
    e.data  = d;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Write-port monitor: every issued write must match the queue head.
  always @(negedge Clk) begin
    if (!Reset && Register_Write) begin
      if (sb.size() == 0) begin
        check("unexpected_write", {27'd0, Write_Reg}, 64'hFFFF);
      end else begin
        wr_slot_t e;
        e = sb.pop_front();
        check("wr_addr", {59'd0, Write_Reg}, {59'd0, e.addr});
        check("wr_data", {32'd0, Register_Write_Data}, {32'd0, e.data});
        rf[Write_Reg] = Register_Write_Data;
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    Reset = 1'b1;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    Read_Reg_1 = '0; Read_Reg_2 = '0;
    tick(); tick();
    check("rst_ready0", {63'd0, req0_ready}, 64'd1);
    check("rst_ready1", {63'd0, req1_ready}, 64'd1);
    check("rst_wr", {63'd0, Register_Write}, 64'd0);
    check("rst_pending", {32'd0, pending}, 64'd0);
    check("rst_wreg", {59'd0, Write_Reg}, 64'd0);
    Reset = 1'b0;

    // Single write
    tick();
    req0_valid = 1'b1; req0_addr = 5'd2; req0_data = 32'd40; Read_Reg_1 = 5'd2;
    expect_write(5'd2, 32'd40);
    check("t1_ready", {63'd0, req0_ready}, 64'd1);
    tick();
    req0_valid = 1'b0;
    check("t1_we", {63'd0, Register_Write}, 64'd1);
    check("t1_pend", {32'd0, pending}, 64'h4);
    check("t1_haz", {63'd0, hazard_1}, 64'd1);
    tick();
    check("t1_pend_clr", {32'd0, pending}, 64'd0);
    check("t1_haz_clr", {63'd0, hazard_1}, 64'd0);

    // Simultaneous requests, rr starts at requester 0
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'd80;
    req1_valid = 1'b1; req1_addr = 5'd8; req1_data = 32'd160;
    expect_write(5'd4, 32'd80);
    expect_write(5'd8, 32'd160);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("t2_pend_both", {32'd0, pending}, 64'h110);
    check("t2_ready0", {63'd0, req0_ready}, 64'd1);
    check("t2_ready1", {63'd0, req1_ready}, 64'd0);
    tick();
    check("t2_pend_one", {32'd0, pending}, 64'h100);
    tick();
    check("t2_ready0_idle", {63'd0, req0_ready}, 64'd1);
    check("t2_ready1_idle", {63'd0, req1_ready}, 64'd1);
    check("t2_pend_idle", {32'd0, pending}, 64'd0);

    // Same address on consecutive edges
    req1_valid = 1'b1; req1_addr = 5'd16; req1_data = 32'd320;
    expect_write(5'd16, 32'd320);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd16; req0_data = 32'd999;
    expect_write(5'd16, 32'd999);
    check("t3_ready0", {63'd0, req0_ready}, 64'd1);
    tick();
    req0_valid = 1'b0;
    tick(); tick();

    // Both full on one address, slot 0 older (rr now points at requester 1)
    req0_valid = 1'b1; req0_addr = 5'd20; req0_data = 32'd1;
    req1_valid = 1'b1; req1_addr = 5'd24; req1_data = 32'd2;
    expect_write(5'd24, 32'd2);
    tick();
    req0_valid = 1'b0;
    req1_addr = 5'd20; req1_data = 32'd3;
    expect_write(5'd20, 32'd1);
    expect_write(5'd20, 32'd3);
    check("t4_refill_ready1", {63'd0, req1_ready}, 64'd1);
    tick();
    req1_valid = 1'b0;
    tick(); tick();

    // Both full on one address, slot 1 older (rr back at requester 0)
    req0_valid = 1'b1; req0_addr = 5'd28; req0_data = 32'd5;
    req1_valid = 1'b1; req1_addr = 5'd12; req1_data = 32'd6;
    expect_write(5'd28, 32'd5);
    tick();
    req1_valid = 1'b0;
    req0_addr = 5'd12; req0_data = 32'd7;
    expect_write(5'd12, 32'd6);
    expect_write(5'd12, 32'd7);
    tick();
    req0_valid = 1'b0;
    tick(); tick();

    // Zero discard
    req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'd20;
    check("t5_ready", {63'd0, req0_ready}, 64'd1);
    tick();
    req0_valid = 1'b0;
    check("t5_we", {63'd0, Register_Write}, 64'd0);
    check("t5_pend", {32'd0, pending}, 64'd0);
    tick();

    // Hazard flags
    req0_valid = 1'b1; req0_addr = 5'd31; req0_data = 32'd77;
    Read_Reg_1 = 5'd31; Read_Reg_2 = 5'd8;
    expect_write(5'd31, 32'd77);
    tick();
    req0_valid = 1'b0;
    check("t6_haz1", {63'd0, hazard_1}, 64'd1);
    check("t6_haz2", {63'd0, hazard_2}, 64'd0);
    tick();
    check("t6_haz1_clr", {63'd0, hazard_1}, 64'd0);
    check("t6_haz2_clr", {63'd0, hazard_2}, 64'd0);

    // Async reset with both slots full: held writes are lost
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'd11;
    req1_valid = 1'b1; req1_addr = 5'd5; req1_data = 32'd22;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("t7_pend_full", {32'd0, pending}, 64'h28);
    #1 Reset = 1'b1;
    #1;
    check("t7_we", {63'd0, Register_Write}, 64'd0);
    check("t7_pend", {32'd0, pending}, 64'd0);
    check("t7_ready0", {63'd0, req0_ready}, 64'd1);
    check("t7_ready1", {63'd0, req1_ready}, 64'd1);
    tick();
    Reset = 1'b0;
    tick(); tick(); tick();

    check("rf2", {32'd0, rf[2]}, 64'd40);
    check("rf4", {32'd0, rf[4]}, 64'd80);
    check("rf8", {32'd0, rf[8]}, 64'd160);
    check("rf16", {32'd0, rf[16]}, 64'd999);
    check("rf20", {32'd0, rf[20]}, 64'd3);
    check("rf12", {32'd0, rf[12]}, 64'd7);
    check("rf0", {32'd0, rf[0]}, 64'd0);
    check("rf3", {32'd0, rf[3]}, 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
